l2_miss_sequencer: RTL

Sequences an L2 miss for the 8-way, 32-bit-address L2 model (11-bit tag, 15-bit index, 6-bit byte offset, MESI states). It accepts one miss at a time together with the victim chosen by the replacement logic, and performs the required steps in order: dirty-victim recall from L1, bus write-back, L1 eviction, bus fetch (READ or RWIM), tag/state fill and L1 line delivery. It sits between the L2 tag/state array and the bus/L1 message interfaces. Bus-op, snoop-result and L2-to-L1 message encodings are the shared cache definitions.

---
 rtl/l2_miss_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/l2_miss_sequencer.sv
// L2 miss sequencer: recall/write-back/evict the victim, fetch the missing line,
// write tag/state and deliver the line to L1, one miss at a time.
module l2_miss_sequencer #(
    parameter int TAG_W    = 11,
    parameter int INDEX_W  = 15,
    parameter int OFFSET_W = 6,
    parameter int WAY_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [31:0]        req_addr,
    input  logic [WAY_W-1:0]   victim_way,
    input  logic               victim_valid,
    input  logic               victim_dirty,
    input  logic [TAG_W-1:0]   victim_tag,
    output logic               bus_valid,
    output logic [2:0]         bus_op,
    output logic [31:0]        bus_addr,
    input  logic               bus_ack,
    input  logic [1:0]         snoop_result,
    output logic               l1_valid,
    output logic [2:0]         l1_msg,
    output logic [31:0]        l1_addr,
    input  logic               l1_ack,
    output logic               fill_valid,
    output logic [WAY_W-1:0]   fill_way,
    output logic [INDEX_W-1:0] fill_index,
    output logic [TAG_W-1:0]   fill_tag,
    output logic [1:0]         fill_state,
    output logic [15:0]        wb_count
);

    localparam logic [2:0] BUS_READ  = 3'd1;
    localparam logic [2:0] BUS_WRITE = 3'd2;
    localparam logic [2:0] BUS_RWIM  = 3'd4;
    localparam logic [2:0] L1_GETLINE   = 3'd1;
    localparam logic [2:0] L1_SENDLINE  = 3'd2;
    localparam logic [2:0] L1_EVICTLINE = 3'd4;
    localparam logic [1:0] SNOOP_NOHIT = 2'd0;
    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_RECALL, S_WRBACK, S_EVICT, S_FETCH, S_FILL, S_SEND
    } state_t;

    state_t               state, state_nx;
    logic                 wr_q;
    logic [TAG_W-1:0]     rtag_q;
    logic [INDEX_W-1:0]   idx_q;
    logic [WAY_W-1:0]     vway_q;
    logic [TAG_W-1:0]     vtag_q;
    logic [1:0]           snoop_q;
    logic [15:0]          wb_cnt;
    logic [31:0]          vaddr, raddr;
    logic                 unused_offset;

    assign unused_offset = ^req_addr[OFFSET_W-1:0];
    assign vaddr    = {vtag_q, idx_q, {OFFSET_W{1'b0}}};
    assign raddr    = {rtag_q, idx_q, {OFFSET_W{1'b0}}};
    assign wb_count = wb_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            wr_q    <= 1'b0;
            rtag_q  <= '0;
            idx_q   <= '0;
            vway_q  <= '0;
            vtag_q  <= '0;
            snoop_q <= '0;
            wb_cnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && req_valid) begin
                wr_q   <= req_write;
                rtag_q <= req_addr[OFFSET_W+INDEX_W +: TAG_W];
                idx_q  <= req_addr[OFFSET_W +: INDEX_W];
                vway_q <= victim_way;
                vtag_q <= victim_tag;
            end
            if (state == S_FETCH && bus_ack)
                snoop_q <= snoop_result;
            if (state == S_WRBACK && bus_ack && wb_cnt != '1)
                wb_cnt <= wb_cnt + 16'd1;
        end
    end

    // Outputs are pure state decode; payload registers are idle-zeroed only by reset,
    // so address/fill fields are gated to their owning state.
    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        bus_valid  = 1'b0;
        bus_op     = '0;
        bus_addr   = '0;
        l1_valid   = 1'b0;
        l1_msg     = '0;
        l1_addr    = '0;
        fill_valid = 1'b0;
        fill_way   = '0;
        fill_index = '0;
        fill_tag   = '0;
        fill_state = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (victim_valid && victim_dirty) state_nx = S_RECALL;
                    else if (victim_valid)            state_nx = S_EVICT;
                    else                              state_nx = S_FETCH;
                end
            end
            S_RECALL: begin
                l1_valid = 1'b1;
                l1_msg   = L1_GETLINE;
                l1_addr  = vaddr;
                if (l1_ack) state_nx = S_WRBACK;
            end
            S_WRBACK: begin
                bus_valid = 1'b1;
                bus_op    = BUS_WRITE;
                bus_addr  = vaddr;
                if (bus_ack) state_nx = S_EVICT;
            end
            S_EVICT: begin
                l1_valid = 1'b1;
                l1_msg   = L1_EVICTLINE;
                l1_addr  = vaddr;
                if (l1_ack) state_nx = S_FETCH;
            end
            S_FETCH: begin
                bus_valid = 1'b1;
                bus_op    = wr_q ? BUS_RWIM : BUS_READ;
                bus_addr  = raddr;
                if (bus_ack) state_nx = S_FILL;
            end
            S_FILL: begin
                fill_valid = 1'b1;
                fill_way   = vway_q;
                fill_index = idx_q;
                fill_tag   = rtag_q;
                if (wr_q)                      fill_state = MESI_M;
                else if (snoop_q == SNOOP_NOHIT) fill_state = MESI_E;
                else                           fill_state = MESI_S;
                state_nx = S_SEND;
            end
            S_SEND: begin
                l1_valid = 1'b1;
                l1_msg   = L1_SENDLINE;
                l1_addr  = raddr;
                if (l1_ack) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
